vx_ptw_arbiter: RTL and testbench

Sequences and shares the single page-table walker (VX_PTW) among NUM_REQS TLB miss sources, such as I-TLB and D-TLB per core. It accepts miss requests round-robin and issues one walk at a time to the PTW. It captures the PTW result and returns the translation or fault to the requester(s) that asked for it. It sits between the TLBs and VX_PTW, and owns the PTW's request/response handshake.

---
 rtl/vx_ptw_pkg.sv | 24 ++
 rtl/vx_rr_arbiter.sv | 38 +++
 rtl/vx_ptw_arbiter.sv | 134 +++++++++++++
 tb/tb_vx_ptw_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_ptw_pkg.sv
// vx_ptw_pkg: shared definitions for the page-table-walker arbiter and VX_PTW.
//   - default Sv39 VPN / PPN widths
//   - walk fault codes (shared encoding with VX_PTW)
//   - arbiter FSM state encoding
package vx_ptw_pkg;

    localparam int VPN_WIDTH_DEF = 27;
    localparam int PPN_WIDTH_DEF = 44;

    typedef enum logic [1:0] {
        NO_ERROR           = 2'd0,
        INVALID_PAGE_FAULT = 2'd1,
        NO_LEAF_PAGE_FAULT = 2'd2,
        PERM_PAGE_FAULT    = 2'd3
    } ptw_err_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } ptw_arb_state_e;

endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: combinational round-robin pick.
// Selects the first set bit of i_req at or after i_ptr, wrapping around.
//   i_req   [N-1:0]     request vector
//   i_ptr   [PTR_W-1:0] priority start position (must be < N)
//   o_grant [N-1:0]     one-hot grant (zero when no request)
//   o_idx   [PTR_W-1:0] index of the granted bit
//   o_valid             any request present
module vx_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            // Walk positions ptr, ptr+1, ... modulo N; first hit wins.
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_valid && i_req[w_idx[PTR_W-1:0]]) begin
                o_valid                    = 1'b1;
                o_grant[w_idx[PTR_W-1:0]]  = 1'b1;
                o_idx                      = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vx_ptw_arbiter.sv
// vx_ptw_arbiter: shares one page-table walker among NUM_REQS TLB miss sources.
// One walk in flight; requests accepted round-robin; result broadcast to the
// owner mask for one cycle.
// Optional feature macro: PTW_ARB_MERGE_EN -- while a walk is being issued or
// awaited, other requesters asking for the same VPN join the in-flight walk.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_vpn/req_ready    TLB miss request side (per requester)
//   rsp_valid/rsp_ppn/rsp_error    response strobe per requester, shared data
//   ptw_req_* / ptw_rsp_*          walker handshake
//   busy                           FSM not idle
module vx_ptw_arbiter
    import vx_ptw_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int VPN_WIDTH = VPN_WIDTH_DEF,
    parameter int PPN_WIDTH = PPN_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*VPN_WIDTH-1:0] req_vpn,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [PPN_WIDTH-1:0]          rsp_ppn,
    output logic [1:0]                    rsp_error,
    output logic                          ptw_req_valid,
    input  logic                          ptw_req_ready,
    output logic [VPN_WIDTH-1:0]          ptw_req_vpn,
    input  logic                          ptw_rsp_valid,
    input  logic [PPN_WIDTH-1:0]          ptw_rsp_ppn,
    input  logic [1:0]                    ptw_rsp_error,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQS);

    ptw_arb_state_e                      r_state, w_state_nxt;
    logic [PTR_W-1:0]                    r_rr_ptr;
    logic [VPN_WIDTH-1:0]                r_vpn;
    logic [NUM_REQS-1:0]                 r_mask;
    logic [PPN_WIDTH-1:0]                r_ppn;
    ptw_err_e                            r_err;

    logic [NUM_REQS-1:0][VPN_WIDTH-1:0]  w_vpn_arr;
    logic [NUM_REQS-1:0]                 w_rr_grant;
    logic [PTR_W-1:0]                    w_rr_idx;
    logic                                w_rr_valid;
    logic [NUM_REQS-1:0]                 w_grant;
    logic [NUM_REQS-1:0]                 w_merge;

    assign w_vpn_arr = req_vpn;

    vx_rr_arbiter #(.N(NUM_REQS), .PTR_W(PTR_W)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    assign w_grant = (r_state == ARB_IDLE) ? w_rr_grant : '0;

`ifdef PTW_ARB_MERGE_EN
    // Join window closes on the cycle the walk result arrives, so a late
    // joiner can never miss the broadcast.
    logic w_merge_win;
    assign w_merge_win = (r_state == ARB_ISSUE) ||
                         ((r_state == ARB_WAIT) && !ptw_rsp_valid);

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_merge
        assign w_merge[gi] = w_merge_win && req_valid[gi] && !r_mask[gi] &&
                             (w_vpn_arr[gi] == r_vpn);
    end
`else
    assign w_merge = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_rr_valid)    w_state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (ptw_req_ready) w_state_nxt = ARB_WAIT;
            ARB_WAIT:  if (ptw_rsp_valid) w_state_nxt = ARB_RESP;
            ARB_RESP:                     w_state_nxt = ARB_IDLE;
            default:                      w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_vpn    <= '0;
            r_mask   <= '0;
            r_ppn    <= '0;
            r_err    <= NO_ERROR;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_rr_valid) begin
                        r_vpn    <= w_vpn_arr[w_rr_idx];
                        r_mask   <= w_rr_grant;
                        r_rr_ptr <= (w_rr_idx == PTR_W'(NUM_REQS - 1)) ? '0
                                                                        : w_rr_idx + 1'b1;
                    end
                end
                ARB_ISSUE: r_mask <= r_mask | w_merge;
                ARB_WAIT: begin
                    r_mask <= r_mask | w_merge;
                    if (ptw_rsp_valid) begin
                        r_ppn <= ptw_rsp_ppn;
                        r_err <= ptw_err_e'(ptw_rsp_error);
                    end
                end
                ARB_RESP: r_mask <= '0;
                default:  r_mask <= '0;
            endcase
        end
    end

    assign req_ready     = w_grant | w_merge;
    assign rsp_valid     = (r_state == ARB_RESP) ? r_mask : '0;
    assign rsp_ppn       = (r_state == ARB_RESP) ? r_ppn : '0;
    assign rsp_error     = (r_state == ARB_RESP) ? r_err : NO_ERROR;
    assign ptw_req_valid = (r_state == ARB_ISSUE);
    assign ptw_req_vpn   = r_vpn;
    assign busy          = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_vx_ptw_arbiter.sv
// Directed bench for vx_ptw_arbiter (NUM_REQS=4, Sv39 widths).
// Inputs change #1 after posedge; outputs checked #1 later.
module tb_vx_ptw_arbiter;

    localparam int NR = 4;
    localparam int VW = 27;
    localparam int PW = 44;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*VW-1:0]  req_vpn = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [PW-1:0]     rsp_ppn;
    logic [1:0]        rsp_error;
    logic              ptw_req_valid;
    logic              ptw_req_ready = 1'b0;
    logic [VW-1:0]     ptw_req_vpn;
    logic              ptw_rsp_valid = 1'b0;
    logic [PW-1:0]     ptw_rsp_ppn = '0;
    logic [1:0]        ptw_rsp_error = '0;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    vx_ptw_arbiter #(.NUM_REQS(NR), .VPN_WIDTH(VW), .PPN_WIDTH(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_vpn       (req_vpn),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ppn       (rsp_ppn),
        .rsp_error     (rsp_error),
        .ptw_req_valid (ptw_req_valid),
        .ptw_req_ready (ptw_req_ready),
        .ptw_req_vpn   (ptw_req_vpn),
        .ptw_rsp_valid (ptw_rsp_valid),
        .ptw_rsp_ppn   (ptw_rsp_ppn),
        .ptw_rsp_error (ptw_rsp_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vpn(input int i, input logic [VW-1:0] v);
        req_vpn[i*VW +: VW] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'h0);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, ".rsp_ppn"}, 64'(rsp_ppn), 64'h0);
        chk({tag, ".rsp_error"}, 64'(rsp_error), 64'h0);
        chk({tag, ".ptw_req_valid"}, 64'(ptw_req_valid), 64'h0);
        chk({tag, ".ptw_req_vpn"}, 64'(ptw_req_vpn), 64'h0);
        chk({tag, ".busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        // ---------------- reset state
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b1;

        // ---------------- round-robin: all four requesting from reset
        for (int i = 0; i < NR; i++) set_vpn(i, VW'(32'h100 * i + 1));
        req_valid     = 4'b1111;
        ptw_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d.grant", k), 64'(req_ready), 64'(1 << (k % NR)));
            tick();
            chk($sformatf("rr%0d.vpn", k), 64'(ptw_req_vpn), 64'(32'h100 * (k % NR) + 1));
            tick();
            ptw_rsp_valid = 1'b1;
            ptw_rsp_ppn   = PW'(k + 16);
            #1;
            chk($sformatf("rr%0d.no_ready_wait", k), 64'(req_ready), 64'h0);
            tick();
            ptw_rsp_valid = 1'b0;
            chk($sformatf("rr%0d.rsp_valid", k), 64'(rsp_valid), 64'(1 << (k % NR)));
            chk($sformatf("rr%0d.rsp_ppn", k), 64'(rsp_ppn), 64'(k + 16));
            tick();
        end
        req_valid = '0;
        // rr_ptr now 1

        // ---------------- single request on requester 2
        set_vpn(2, 27'h1234);
        req_valid = 4'b0100;
        #1;
        chk("single.ready_T", 64'(req_ready), 64'h4);
        chk("single.busy_T", 64'(busy), 64'h0);
        tick();
        req_valid = '0;
        chk("single.ptw_valid", 64'(ptw_req_valid), 64'h1);
        chk("single.ptw_vpn", 64'(ptw_req_vpn), 64'h1234);
        chk("single.busy", 64'(busy), 64'h1);
        tick();
        ptw_rsp_valid = 1'b1;
        ptw_rsp_ppn   = 44'hABC;
        ptw_rsp_error = 2'd0;
        #1;
        chk("single.no_rsp_early", 64'(rsp_valid), 64'h0);
        tick();
        ptw_rsp_valid = 1'b0;
        chk("single.rsp_valid", 64'(rsp_valid), 64'h4);
        chk("single.rsp_ppn", 64'(rsp_ppn), 64'hABC);
        chk("single.rsp_err", 64'(rsp_error), 64'h0);
        tick();
        chk("single.rsp_one_cycle", 64'(rsp_valid), 64'h0);
        chk("single.idle", 64'(busy), 64'h0);
        // rr_ptr now 3

        // ---------------- PTW backpressure + fault pass-through on requester 1
        ptw_req_ready = 1'b0;
        set_vpn(1, 27'h777);
        set_vpn(0, 27'h888);
        req_valid = 4'b0010;
        #1;
        chk("bp.grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b0001;   // another requester waits; must not be accepted
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d.ptw_valid", c), 64'(ptw_req_valid), 64'h1);
            chk($sformatf("bp%0d.ptw_vpn", c), 64'(ptw_req_vpn), 64'h777);
            chk($sformatf("bp%0d.busy", c), 64'(busy), 64'h1);
            chk($sformatf("bp%0d.no_ready", c), 64'(req_ready), 64'h0);
            tick();
        end
        ptw_req_ready = 1'b1;
        tick();
        req_valid     = '0;
        ptw_rsp_valid = 1'b1;
        ptw_rsp_ppn   = 44'h5;
        ptw_rsp_error = 2'd3;
        tick();
        ptw_rsp_valid = 1'b0;
        ptw_rsp_error = 2'd0;
        chk("fault.rsp_valid", 64'(rsp_valid), 64'h2);
        chk("fault.rsp_error", 64'(rsp_error), 64'h3);
        tick();
        // stray walker response while idle
        ptw_rsp_valid = 1'b1;
        #1;
        chk("stray.rsp_valid_now", 64'(rsp_valid), 64'h0);
        tick();
        ptw_rsp_valid = 1'b0;
        chk("stray.rsp_valid_next", 64'(rsp_valid), 64'h0);
        chk("stray.busy", 64'(busy), 64'h0);
        // rr_ptr now 2

        // ---------------- same-VPN requests from 0 and 3
        set_vpn(0, 27'h55);
        set_vpn(3, 27'h55);
        req_valid = 4'b0001;
        #1;
        chk("mrg.grant0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        tick();             // WAIT
        req_valid = 4'b1000;
        #1;
`ifdef PTW_ARB_MERGE_EN
        chk("mrg.ready3", 64'(req_ready), 64'h8);
`else
        chk("mrg.ready3", 64'(req_ready), 64'h0);
`endif
        tick();
`ifdef PTW_ARB_MERGE_EN
        req_valid = '0;
`endif
        ptw_rsp_valid = 1'b1;
        ptw_rsp_ppn   = 44'h99;
        #1;
        chk("mrg.no_ready_rsp", 64'(req_ready), 64'h0);
        tick();
        ptw_rsp_valid = 1'b0;
`ifdef PTW_ARB_MERGE_EN
        chk("mrg.rsp_valid", 64'(rsp_valid), 64'h9);
`else
        chk("mrg.rsp_valid", 64'(rsp_valid), 64'h1);
`endif
        chk("mrg.rsp_ppn", 64'(rsp_ppn), 64'h99);
        tick();
`ifdef PTW_ARB_MERGE_EN
        chk("mrg.no_second", 64'(req_ready), 64'h0);
`else
        chk("mrg.second_grant", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        chk("mrg.second_vpn", 64'(ptw_req_vpn), 64'h55);
        tick();
        ptw_rsp_valid = 1'b1;
        ptw_rsp_ppn   = 44'h99;
        tick();
        ptw_rsp_valid = 1'b0;
        chk("mrg.second_rsp", 64'(rsp_valid), 64'h8);
        tick();
`endif

        // ---------------- async reset during WAIT
        set_vpn(1, 27'h321);
        req_valid = 4'b0010;
        #1;
        chk("rst.grant1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();             // WAIT; rr_ptr is 2 here
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("rst.mid_walk");
        tick();
        reset = 1'b1;
        // pointer back at 0: requester 0 wins over 3
        set_vpn(0, 27'h4242);
        req_valid = 4'b1001;
        #1;
        chk("rst.grant_after", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("rst.ptw_vpn", 64'(ptw_req_vpn), 64'h4242);
        tick();
        ptw_rsp_valid = 1'b1;
        ptw_rsp_ppn   = 44'hFEED;
        ptw_rsp_error = 2'd1;
        tick();
        ptw_rsp_valid = 1'b0;
        ptw_rsp_error = 2'd0;
        chk("rst.rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rst.rsp_ppn", 64'(rsp_ppn), 64'hFEED);
        chk("rst.rsp_error", 64'(rsp_error), 64'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
